// File: rtl/vga_plot_arbiter.sv
// vga_plot_arbiter
//   Shares the single pixel-write port of vga_adapter among NREQ drawing engines.
//   Index 0 has the highest priority. Ownership is non-preemptive and lasts for a
//   whole job: an engine keeps the port until it drops its request, so frame jobs
//   never interleave.
//
//   Owner pixels are registered onto the vga_* outputs with a latency of one cycle.
//   Pixels with x >= XMAX or y >= YMAX are dropped. After an owner releases the
//   port, one gap cycle with no grant follows before the next owner is granted.
//
//   A watchdog takes the port back from an owner that goes TIMEOUT cycles without
//   plotting. That owner gets a sticky timeout flag. It is also masked until its
//   request has been seen low. TIMEOUT = 0 disables the watchdog.
//
// Parameters
//   NREQ     number of requesters
//   TIMEOUT  idle cycles before an owner's grant is revoked (0 = off)
//   XMAX     screen width
//   YMAX     screen height
//
// Ports
//   clock       in   system clock
//   resetn      in   asynchronous active-low reset
//   req         in   level request per engine, held for the whole job
//   plot_in     in   per-engine pixel strobe
//   x_in        in   packed x, requester i on [9i+8:9i]
//   y_in        in   packed y, requester i on [8i+7:8i]
//   colour_in   in   packed colour, requester i on [3i+2:3i]
//   gnt         out  registered one-hot grant
//   vga_x       out  x to vga_adapter (held while vga_plot is low)
//   vga_y       out  y to vga_adapter (held while vga_plot is low)
//   vga_colour  out  colour to vga_adapter (held while vga_plot is low)
//   vga_plot    out  plot strobe to vga_adapter
//   busy        out  high while any grant is held
//   pix_cnt     out  pixels forwarded in the current grant (saturating)
//   to_flag     out  sticky per-requester timeout flags

module vga_plot_arbiter #(
  parameter int unsigned NREQ    = 3,
  parameter int unsigned TIMEOUT = 1023,
  parameter int unsigned XMAX    = 320,
  parameter int unsigned YMAX    = 240
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ-1:0]     plot_in,
  input  logic [9*NREQ-1:0]   x_in,
  input  logic [8*NREQ-1:0]   y_in,
  input  logic [3*NREQ-1:0]   colour_in,
  output logic [NREQ-1:0]     gnt,
  output logic [8:0]          vga_x,
  output logic [7:0]          vga_y,
  output logic [2:0]          vga_colour,
  output logic                vga_plot,
  output logic                busy,
  output logic [16:0]         pix_cnt,
  output logic [NREQ-1:0]     to_flag
);

  localparam int unsigned OWN_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
  // The idle counter only has to reach TIMEOUT. The +2 keeps the width at
  // least 1 when TIMEOUT is 0 or 1.
  localparam int unsigned IDLE_W = $clog2(TIMEOUT + 2);
  localparam logic [IDLE_W-1:0] TO_VAL = IDLE_W'(TIMEOUT);
  localparam bit WDOG_EN = (TIMEOUT != 0);
  // Limits are one bit wider than the coordinates so XMAX = 512 or YMAX = 256 still fit.
  localparam logic [9:0] XLIM = 10'(XMAX);
  localparam logic [8:0] YLIM = 9'(YMAX);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN  = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  logic [1:0]        r_state,   r_state_d;
  logic [OWN_W-1:0]  r_owner,   r_owner_d;
  logic [NREQ-1:0]   r_gnt,     r_gnt_d;
  logic [NREQ-1:0]   r_mask,    r_mask_d;
  logic [NREQ-1:0]   r_to_flag, r_to_flag_d;
  logic [8:0]        r_x,       r_x_d;
  logic [7:0]        r_y,       r_y_d;
  logic [2:0]        r_c,       r_c_d;
  logic              r_plot,    r_plot_d;
  logic [16:0]       r_pix,     r_pix_d;
  logic [IDLE_W-1:0] r_idle,    r_idle_d;

  logic [NREQ-1:0]   w_elig;
  logic              w_any;
  logic [NREQ-1:0]   w_pick_oh;
  logic [OWN_W-1:0]  w_pick;
  logic              w_own_req;
  logic              w_own_plot;
  logic [8:0]        w_own_x;
  logic [7:0]        w_own_y;
  logic [2:0]        w_own_c;
  logic              w_on_screen;
  logic [IDLE_W-1:0] w_idle_inc;
  logic              w_timeout;

  // Masked requesters stay ineligible until their request has been seen low.
  assign w_elig    = req & ~r_mask;
  assign w_any     = |w_elig;
  // Isolate the lowest set bit, which is the highest-priority eligible requester.
  assign w_pick_oh = w_elig & ~(w_elig - NREQ'(1));

  always_comb begin
    w_pick = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (w_elig[i]) w_pick = OWN_W'(i);
    end
  end

  // Mux the owner's request and pixel fields out of the packed inputs.
  always_comb begin
    w_own_req  = 1'b0;
    w_own_plot = 1'b0;
    w_own_x    = '0;
    w_own_y    = '0;
    w_own_c    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_owner == OWN_W'(i)) begin
        w_own_req  = req[i];
        w_own_plot = plot_in[i];
        w_own_x    = x_in[9*i +: 9];
        w_own_y    = y_in[8*i +: 8];
        w_own_c    = colour_in[3*i +: 3];
      end
    end
  end

  assign w_on_screen = ({1'b0, w_own_x} < XLIM) && ({1'b0, w_own_y} < YLIM);
  assign w_idle_inc  = r_idle + IDLE_W'(1);
  assign w_timeout   = WDOG_EN && !w_own_plot && (w_idle_inc == TO_VAL);

  always_comb begin
    r_state_d   = r_state;
    r_owner_d   = r_owner;
    r_gnt_d     = r_gnt;
    r_mask_d    = r_mask & req;
    r_to_flag_d = r_to_flag;
    r_x_d       = r_x;
    r_y_d       = r_y;
    r_c_d       = r_c;
    r_plot_d    = 1'b0;
    r_pix_d     = r_pix;
    r_idle_d    = r_idle;

    case (r_state)
      // The gap cycle already has gnt low. Arbitrating on its exit edge makes
      // the hand-over two edges after the previous owner dropped its request.
      ST_IDLE, ST_GAP: begin
        if (w_any) begin
          r_owner_d = w_pick;
          r_gnt_d   = w_pick_oh;
          r_pix_d   = '0;
          r_idle_d  = '0;
          r_state_d = ST_OWN;
        end else begin
          r_state_d = ST_IDLE;
        end
      end

      ST_OWN: begin
        // A pixel strobed in the same cycle as the request falls is still forwarded.
        if (w_own_plot && w_on_screen) begin
          r_plot_d = 1'b1;
          r_x_d    = w_own_x;
          r_y_d    = w_own_y;
          r_c_d    = w_own_c;
          if (r_pix != '1) r_pix_d = r_pix + 17'd1;
        end
        r_idle_d = w_own_plot ? '0 : w_idle_inc;

        if (!w_own_req) begin
          r_gnt_d   = '0;
          r_state_d = ST_GAP;
        end else if (w_timeout) begin
          // While in OWN, r_gnt is the one-hot owner.
          r_gnt_d     = '0;
          r_to_flag_d = r_to_flag | r_gnt;
          r_mask_d    = (r_mask & req) | r_gnt;
          r_state_d   = ST_GAP;
        end
      end

      default: begin
        r_gnt_d   = '0;
        r_state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state   <= ST_IDLE;
      r_owner   <= '0;
      r_gnt     <= '0;
      r_mask    <= '0;
      r_to_flag <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_c       <= '0;
      r_plot    <= 1'b0;
      r_pix     <= '0;
      r_idle    <= '0;
    end else begin
      r_state   <= r_state_d;
      r_owner   <= r_owner_d;
      r_gnt     <= r_gnt_d;
      r_mask    <= r_mask_d;
      r_to_flag <= r_to_flag_d;
      r_x       <= r_x_d;
      r_y       <= r_y_d;
      r_c       <= r_c_d;
      r_plot    <= r_plot_d;
      r_pix     <= r_pix_d;
      r_idle    <= r_idle_d;
    end
  end

  assign gnt        = r_gnt;
  assign busy       = |r_gnt;
  assign vga_x      = r_x;
  assign vga_y      = r_y;
  assign vga_colour = r_c;
  assign vga_plot   = r_plot;
  assign pix_cnt    = r_pix;
  assign to_flag    = r_to_flag;

endmodule
